smi_mem_lib_fuzz_multi_param_gen: RTL and testbench

SMI_MEM_LIB_FUZZ_MULTI_PARAM_GEN -- requirements
Module: smi_mem_lib_fuzz_multi_param_gen

---
 rtl/smi_mem_lib_fuzz_multi_param_gen.sv | 218 +++++++++++++++++++++
 tb/tb_smi_mem_lib_fuzz_multi_param_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_mem_lib_fuzz_multi_param_gen.sv
// Fuzz parameter generator: spreads randomized, aligned bursts over per-channel
// windows of a memory block and hands them out through single-entry channel buffers.
module smi_mem_lib_fuzz_multi_param_gen #(
  parameter int          NumChannels    = 4,
  parameter int          MinBurstLength = 64,
  parameter int          MaxBurstLength = 8192,
  parameter int          AlignBytes     = 64,
  parameter logic [63:0] RandSeed       = 64'h373E7B7D27C69FA4
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      configValid,
  input  logic [63:0]               configMemAddrBase,
  input  logic [31:0]               configMemBlockSize,
  input  logic [31:0]               configNumTests,
  input  logic                      configMode,
  output logic                      configStop,
  output logic [NumChannels-1:0]    paramsValid,
  output logic [64*NumChannels-1:0] paramBaseAddr,
  output logic [32*NumChannels-1:0] paramByteLength,
  output logic [64*NumChannels-1:0] paramDataInit,
  output logic [64*NumChannels-1:0] paramDataIncr,
  input  logic [NumChannels-1:0]    paramsStop,
  output logic                      testDone,
  output logic                      configError
);

  localparam int          Log2N     = $clog2(NumChannels);
  localparam int          ChanW     = (NumChannels > 1) ? Log2N : 1;
  localparam logic [31:0] AlignMask = ~(32'(AlignBytes) - 32'd1);
  localparam logic [31:0] AlignLen  = 32'(AlignBytes);
  localparam logic [31:0] MinLen    = 32'(MinBurstLength);
  localparam logic [31:0] MaxLen    = 32'(MaxBurstLength);
  localparam logic [ChanW-1:0] ChanMask = ChanW'(NumChannels - 1);

  typedef enum logic [3:0] {
    Idle, WindowMask, TestCount, SelectChannel, SetOffset, CheckOffset,
    SetLength, CheckLength, SetDataInit, SetDataIncr, Wait, Drain
  } stateT;

  stateT       state;
  logic [63:0] prngState;
  logic        prngReady;
  logic        prngTake;

  logic [63:0] cfgBase;
  logic [31:0] cfgSw;
  logic [31:0] remaining;
  logic        cfgMode;
  logic [31:0] mask;
  logic [ChanW-1:0] chan;
  logic [ChanW-1:0] chanNext;
  logic [31:0] offset;
  logic [31:0] length;
  logic [63:0] dataInit;
  logic [63:0] dataIncr;
  logic [63:0] baseAddr;

  logic [63:0] bufAddr [NumChannels];
  logic [31:0] bufLen  [NumChannels];
  logic [63:0] bufInit [NumChannels];
  logic [63:0] bufIncr [NumChannels];

  logic        accept;
  logic        maskDone;
  logic        swBad;
  logic        offsetBad;
  logic        lengthBad;
  logic        loadBuf;
  logic [32:0] endSum;
  logic [63:0] chanOffset;

  function automatic logic [63:0] nextRand(input logic [63:0] s);
    logic [63:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  assign accept     = (state == Idle) && configValid && !configStop;
  assign maskDone   = mask >= cfgSw;
  assign swBad      = (cfgSw < MinLen) || (cfgSw < AlignLen);
  assign offsetBad  = offset > (cfgSw >> 1);
  assign endSum     = {1'b0, offset} + {1'b0, length};
  assign lengthBad  = (length < MinLen) || (length > MaxLen) || (endSum > {1'b0, cfgSw});
  assign loadBuf    = (state == Wait) && !paramsValid[chan];
  assign chanOffset = 64'(chan) * 64'(cfgSw);
  assign prngTake   = prngReady && ((state == SetOffset) || (state == SetLength) ||
                      (state == SetDataInit) || (state == SetDataIncr) ||
                      ((state == SelectChannel) && cfgMode));

  // xorshift64 advances only when a draw is consumed, so a config replays identically after reset
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      prngState <= RandSeed;
      prngReady <= 1'b0;
    end else begin
      prngReady <= 1'b1;
      if (prngTake) prngState <= nextRand(prngState);
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state       <= Idle;
      configStop  <= 1'b1;
      testDone    <= 1'b0;
      configError <= 1'b0;
    end else begin
      testDone    <= 1'b0;
      configError <= 1'b0;
      case (state)
        Idle: begin
          if (accept) begin
            state      <= WindowMask;
            configStop <= 1'b1;
          end else begin
            configStop <= 1'b0;
          end
        end
        WindowMask: begin
          if (swBad) begin
            configError <= 1'b1;
            configStop  <= 1'b0;
            state       <= Idle;
          end else if (maskDone) begin
            state <= TestCount;
          end
        end
        TestCount:     state <= (remaining == 32'd0) ? Drain : SelectChannel;
        SelectChannel: if (!cfgMode || prngReady) state <= SetOffset;
        SetOffset:     if (prngReady) state <= CheckOffset;
        CheckOffset:   state <= offsetBad ? SetOffset : SetLength;
        SetLength:     if (prngReady) state <= CheckLength;
        CheckLength:   state <= lengthBad ? SetLength : SetDataInit;
        SetDataInit:   if (prngReady) state <= SetDataIncr;
        SetDataIncr:   if (prngReady) state <= Wait;
        Wait:          if (!paramsValid[chan]) state <= TestCount;
        Drain: begin
          if (paramsValid == '0) begin
            testDone   <= 1'b1;
            configStop <= 1'b0;
            state      <= Idle;
          end
        end
        default:       state <= Idle;
      endcase
    end
  end

  // Datapath registers carry no reset; the FSM never exposes them before they are written
  always_ff @(posedge clk) begin
    case (state)
      Idle: begin
        if (accept) begin
          cfgBase   <= configMemAddrBase;
          cfgSw     <= configMemBlockSize >> Log2N;
          remaining <= configNumTests;
          cfgMode   <= configMode;
          mask      <= 32'd0;
          chanNext  <= '0;
        end
      end
      WindowMask:  if (!maskDone) mask <= {mask[30:0], 1'b1};
      TestCount:   if (remaining != 32'd0) remaining <= remaining - 32'd1;
      SelectChannel: begin
        if (!cfgMode) begin
          chan     <= chanNext;
          chanNext <= (chanNext + ChanW'(1)) & ChanMask;
        end else if (prngReady) begin
          chan <= ChanW'(prngState[63:61]) & ChanMask;
        end
      end
      SetOffset:   if (prngReady) offset <= prngState[63:32] & (mask >> 1) & AlignMask;
      SetLength:   if (prngReady) length <= prngState[63:32] & mask & AlignMask;
      SetDataInit: begin
        if (prngReady) begin
          dataInit <= prngState;
          baseAddr <= cfgBase + chanOffset + 64'(offset);
        end
      end
      SetDataIncr: if (prngReady) dataIncr <= prngState;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      paramsValid <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (loadBuf && (chan == ChanW'(c))) paramsValid[c] <= 1'b1;
        else if (!paramsStop[c])            paramsValid[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (loadBuf && (chan == ChanW'(c))) begin
        bufAddr[c] <= baseAddr;
        bufLen[c]  <= length;
        bufInit[c] <= dataInit;
        bufIncr[c] <= dataIncr;
      end
    end
  end

  // Outputs read as zero while a channel holds nothing
  for (genvar c = 0; c < NumChannels; c++) begin : gOut
    assign paramBaseAddr[64*c +: 64]   = paramsValid[c] ? bufAddr[c] : 64'd0;
    assign paramByteLength[32*c +: 32] = paramsValid[c] ? bufLen[c]  : 32'd0;
    assign paramDataInit[64*c +: 64]   = paramsValid[c] ? bufInit[c] : 64'd0;
    assign paramDataIncr[64*c +: 64]   = paramsValid[c] ? bufIncr[c] : 64'd0;
  end

endmodule

// File: tb/tb_smi_mem_lib_fuzz_multi_param_gen.sv
// Scoreboard bench for the fuzz parameter generator: window/alignment rules,
// channel sequencing, stalls, config errors and reset replay.
module tb_smi_mem_lib_fuzz_multi_param_gen;

  localparam int NumCh  = 4;
  localparam int Align  = 64;
  localparam int MinLen = 64;
  localparam int MaxLen = 8192;

  logic                clk = 1'b0;
  logic                srst = 1'b1;
  logic                configValid = 1'b0;
  logic [63:0]         configMemAddrBase = '0;
  logic [31:0]         configMemBlockSize = '0;
  logic [31:0]         configNumTests = '0;
  logic                configMode = 1'b0;
  logic                configStop;
  logic [NumCh-1:0]    paramsValid;
  logic [64*NumCh-1:0] paramBaseAddr;
  logic [32*NumCh-1:0] paramByteLength;
  logic [64*NumCh-1:0] paramDataInit;
  logic [64*NumCh-1:0] paramDataIncr;
  logic [NumCh-1:0]    paramsStop = '0;
  logic                testDone;
  logic                configError;

  typedef struct {
    int          ch;
    logic [63:0] addr;
    logic [31:0] len;
    logic [63:0] init;
    logic [63:0] incr;
  } xferT;

  int          checks = 0;
  int          errors = 0;
  int          expCh[$];
  bit          strictOrder = 1'b0;
  bit          recording = 1'b0;
  xferT        rec[$];
  int          xferCount = 0;
  int          doneCount = 0;
  int          errCount = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          lastDoneCycle = 0;
  logic [63:0] curBase = '0;
  logic [31:0] curSw = '0;
  bit          randStops = 1'b0;
  logic [NumCh-1:0] stopForce = '0;

  smi_mem_lib_fuzz_multi_param_gen #(
    .NumChannels(NumCh), .MinBurstLength(MinLen), .MaxBurstLength(MaxLen), .AlignBytes(Align)
  ) dut (
    .clk(clk), .srst(srst), .configValid(configValid),
    .configMemAddrBase(configMemAddrBase), .configMemBlockSize(configMemBlockSize),
    .configNumTests(configNumTests), .configMode(configMode), .configStop(configStop),
    .paramsValid(paramsValid), .paramBaseAddr(paramBaseAddr), .paramByteLength(paramByteLength),
    .paramDataInit(paramDataInit), .paramDataIncr(paramDataIncr), .paramsStop(paramsStop),
    .testDone(testDone), .configError(configError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Downstream back-pressure, changed just after each edge
  always @(posedge clk) begin
    #1;
    paramsStop = randStops ? (NumCh'($urandom) | stopForce) : stopForce;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic handleXfer(input int c);
    xferT x;
    int idx;
    logic [63:0] off;
    x.ch = c;
    x.addr = paramBaseAddr[64*c +: 64];
    x.len  = paramByteLength[32*c +: 32];
    x.init = paramDataInit[64*c +: 64];
    x.incr = paramDataIncr[64*c +: 64];
    xferCount++;
    if (recording) rec.push_back(x);
    idx = -1;
    for (int i = 0; i < expCh.size(); i++)
      if (idx < 0 && (expCh[i] == c || expCh[i] < 0)) idx = i;
    if (strictOrder) checkOutput("channel order", 64'(idx), 64'd0);
    else             checkOutput("channel pending", 64'(idx >= 0), 64'd1);
    if (idx >= 0) expCh.delete(idx);
    off = x.addr - curBase - 64'(c) * 64'(curSw);
    checkOutput("offset rule", 64'(off <= 64'(curSw / 2) && (off % Align) == 0), 64'd1);
    checkOutput("length rule", 64'((x.len % Align) == 0 && x.len >= MinLen && x.len <= MaxLen), 64'd1);
    checkOutput("window end", 64'(off + 64'(x.len) <= 64'(curSw)), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!srst) begin
      if (testDone) begin
        doneCount++;
        lastDoneCycle = cycle;
      end
      if (configError) errCount++;
      for (int c = 0; c < NumCh; c++)
        if (paramsValid[c] && !paramsStop[c]) handleXfer(c);
    end
  end

  task automatic applyReset(input int cycles);
    srst = 1'b1;
    configValid = 1'b0;
    @(negedge clk);
    checkOutput("reset configStop", 64'(configStop), 64'd1);
    checkOutput("reset paramsValid", 64'(paramsValid), 64'd0);
    checkOutput("reset testDone", 64'(testDone), 64'd0);
    checkOutput("reset configError", 64'(configError), 64'd0);
    repeat (cycles) @(posedge clk);
    #1 srst = 1'b0;
    expCh.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("configStop after release", 64'(configStop), 64'd0);
  endtask

  task automatic applyStimulus(input logic [63:0] base, input logic [31:0] size,
                               input int tests, input bit mode);
    int n = 0;
    while (configStop !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("configStop idle before config", 64'(configStop), 64'd0);
    curBase = base;
    curSw   = size / NumCh;
    configMemAddrBase  = base;
    configMemBlockSize = size;
    configNumTests     = 32'(tests);
    configMode         = mode;
    configValid        = 1'b1;
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    configValid = 1'b0;
  endtask

  task automatic waitDone(input int budget, input int startDone, input int startErr);
    int n = 0;
    while (doneCount == startDone && errCount == startErr && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("completion within budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, x0, e0, lat, k;
    xferT a[$];

    applyReset(3);

    // Round-robin over 8 tests with no back-pressure
    strictOrder = 1'b1;
    for (int i = 0; i < 8; i++) expCh.push_back(i % NumCh);
    d0 = doneCount; x0 = xferCount; e0 = errCount;
    applyStimulus(64'h1000_0000, 32'h10000, 8, 1'b0);
    waitDone(3000, d0, e0);
    repeat (5) @(negedge clk);
    checkOutput("rr transfers", 64'(xferCount - x0), 64'd8);
    checkOutput("rr done pulses", 64'(doneCount - d0), 64'd1);
    checkOutput("rr queue empty", 64'(expCh.size()), 64'd0);
    checkOutput("rr no error", 64'(errCount - e0), 64'd0);

    // Zero tests: done shortly after the mask has been built
    d0 = doneCount; x0 = xferCount; e0 = errCount;
    applyStimulus(64'h2000_0000, 32'h10000, 0, 1'b0);
    waitDone(100, d0, e0);
    k = 0;
    while ((64'd1 << k) - 64'd1 < 64'(curSw)) k++;
    lat = lastDoneCycle - acceptCycle;
    checkOutput("zero-test latency", 64'(lat >= k + 1 && lat <= k + 5), 64'd1);
    checkOutput("zero-test transfers", 64'(xferCount - x0), 64'd0);
    checkOutput("zero-test done pulses", 64'(doneCount - d0), 64'd1);

    // Sub-window smaller than minimum burst
    d0 = doneCount; x0 = xferCount; e0 = errCount;
    applyStimulus(64'h3000_0000, 32'hC0, 5, 1'b0);
    waitDone(100, d0, e0);
    repeat (3) @(negedge clk);
    checkOutput("error pulses", 64'(errCount - e0), 64'd1);
    checkOutput("error transfers", 64'(xferCount - x0), 64'd0);
    checkOutput("error no done", 64'(doneCount - d0), 64'd0);
    checkOutput("error configStop low", 64'(configStop), 64'd0);

    // Random channels with random stalls
    strictOrder = 1'b0;
    randStops = 1'b1;
    for (int i = 0; i < 100; i++) expCh.push_back(-1);
    d0 = doneCount; x0 = xferCount; e0 = errCount;
    applyStimulus(64'h1000_0000, 32'h10000, 100, 1'b1);
    waitDone(30000, d0, e0);
    randStops = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("random transfers", 64'(xferCount - x0), 64'd100);
    checkOutput("random queue empty", 64'(expCh.size()), 64'd0);
    checkOutput("random done pulses", 64'(doneCount - d0), 64'd1);

    // Channel 2 held stopped: generator blocks at its second item
    stopForce = 4'b0100;
    for (int i = 0; i < 10; i++) expCh.push_back(i % NumCh);
    d0 = doneCount; x0 = xferCount; e0 = errCount;
    applyStimulus(64'h4000_0000, 32'h10000, 10, 1'b0);
    repeat (600) @(negedge clk);
    checkOutput("stalled transfers", 64'(xferCount - x0), 64'd5);
    checkOutput("stalled no done", 64'(doneCount - d0), 64'd0);
    checkOutput("stalled ch2 held", 64'(paramsValid[2]), 64'd1);
    checkOutput("stalled configStop busy", 64'(configStop), 64'd1);
    stopForce = '0;
    waitDone(3000, d0, e0);
    repeat (5) @(negedge clk);
    checkOutput("released transfers", 64'(xferCount - x0), 64'd10);
    checkOutput("released queue empty", 64'(expCh.size()), 64'd0);
    checkOutput("released done pulses", 64'(doneCount - d0), 64'd1);

    // Fresh run, then reset mid-test and replay: sequences must match
    applyReset(2);
    rec.delete();
    recording = 1'b1;
    for (int i = 0; i < 12; i++) expCh.push_back(-1);
    d0 = doneCount; e0 = errCount;
    applyStimulus(64'hFFFF_FFFF_FFFF_8000, 32'h10000, 12, 1'b1);
    waitDone(5000, d0, e0);
    recording = 1'b0;
    a = rec;
    checkOutput("fresh run transfers", 64'(a.size()), 64'd12);

    applyReset(2);
    for (int i = 0; i < 12; i++) expCh.push_back(-1);
    applyStimulus(64'hFFFF_FFFF_FFFF_8000, 32'h10000, 12, 1'b1);
    repeat (60) @(negedge clk);
    applyReset(2);

    rec.delete();
    recording = 1'b1;
    for (int i = 0; i < 12; i++) expCh.push_back(-1);
    d0 = doneCount; e0 = errCount;
    applyStimulus(64'hFFFF_FFFF_FFFF_8000, 32'h10000, 12, 1'b1);
    waitDone(5000, d0, e0);
    repeat (5) @(negedge clk);
    recording = 1'b0;
    checkOutput("replay transfers", 64'(rec.size()), 64'(a.size()));
    for (int i = 0; i < a.size() && i < rec.size(); i++) begin
      checkOutput("replay channel", 64'(rec[i].ch), 64'(a[i].ch));
      checkOutput("replay addr", rec[i].addr, a[i].addr);
      checkOutput("replay length", 64'(rec[i].len), 64'(a[i].len));
      checkOutput("replay dataInit", rec[i].init, a[i].init);
      checkOutput("replay dataIncr", rec[i].incr, a[i].incr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
